// File: rtl/pwm_peripheral.sv
// pwm_peripheral: 16-channel PWM / static output driver.
//
// A prescaler divides clk by CLK_DIV to step an 8-bit PWM counter; one PWM
// period is 256*CLK_DIV clk cycles. Each output bit is either forced low,
// driven high, or follows the shared PWM level. All channels share one
// counter, so every PWM-mode output is phase-aligned.
//
// Build option:
//   PWM_DUTY_SHADOW_EN - when defined, the duty input is captured only at the
//                        period wrap, so a mid-period change waits for the
//                        next period start. When undefined, the duty input
//                        feeds the comparator directly.
//
// No valid/ready handshakes and no FSM: the datapath is a free-running
// prescaler and counter with registered outputs.
`timescale 1ns/1ps

module pwm_peripheral #(
    parameter int unsigned CLK_DIV = 3000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  en_reg_out_7_0,
    input  logic [7:0]  en_reg_out_15_8,
    input  logic [7:0]  en_reg_pwm_7_0,
    input  logic [7:0]  en_reg_pwm_15_8,
    input  logic [7:0]  pwm_duty_cycle,
    output logic [15:0] out,
    output logic        pwm_sync
);

    localparam logic [15:0] PRE_MAX = 16'(CLK_DIV - 1);

    logic [15:0] pre_cnt;
    logic [7:0]  pwm_cnt;
    logic        tick;
    logic        period_wrap;
    logic [7:0]  duty_active;
    logic        pwm_level;
    logic [15:0] en_out;
    logic [15:0] en_pwm;

    assign en_out      = {en_reg_out_15_8, en_reg_out_7_0};
    assign en_pwm      = {en_reg_pwm_15_8, en_reg_pwm_7_0};
    assign tick        = (pre_cnt == PRE_MAX);
    assign period_wrap = tick && (pwm_cnt == 8'hFF);

    // Prescaler: counts 0..CLK_DIV-1; tick marks the last cycle of each step.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pre_cnt <= '0;
        end else if (tick) begin
            pre_cnt <= '0;
        end else begin
            pre_cnt <= pre_cnt + 16'd1;
        end
    end

    // PWM counter: advances once per prescaler step, wraps 255 -> 0 naturally.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pwm_cnt <= '0;
        end else if (tick) begin
            pwm_cnt <= pwm_cnt + 8'd1;
        end
    end

    // Period marker: high during the first cycle of pwm_cnt == 0.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pwm_sync <= 1'b0;
        end else begin
            pwm_sync <= period_wrap;
        end
    end

`ifdef PWM_DUTY_SHADOW_EN
    // Duty shadow: capture the requested duty only at the period boundary,
    // so each period runs with a single consistent duty value.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            duty_active <= 8'h00;
        end else if (period_wrap) begin
            duty_active <= pwm_duty_cycle;
        end
    end
`else
    // Unbuffered duty: the comparator sees the input directly.
    assign duty_active = pwm_duty_cycle;
`endif

    // Shared PWM level; 0xFF is special-cased so full duty never dips at wrap.
    always_comb begin
        pwm_level = 1'b0;
        if (duty_active == 8'hFF) begin
            pwm_level = 1'b1;
        end else begin
            pwm_level = (pwm_cnt < duty_active);
        end
    end

    // Output stage: enable gates everything, then PWM mode selects the level.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out <= 16'h0000;
        end else begin
            out <= en_out & (~en_pwm | {16{pwm_level}});
        end
    end

endmodule
